mux_sel_rr_arbiter: RTL and testbench

//   Upstream select-line generator for n_1_mux_rtl. Arbitrates round-robin among x=2**n

---
 rtl/mux_sel_rr_arbiter_pkg.sv | 30 +++
 rtl/mux_sel_rr_arbiter_rr_pick.sv | 52 +++++
 rtl/mux_sel_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_rr_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux_sel_pkg
// Brief    : Shared types and helpers for the mux select round-robin arbiter:
//            default select width, FSM state enum and a one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mux_sel_pkg;

   localparam int C_N_DEFAULT = 2;
   // Widest select supported by the one-hot helper below.
   localparam int C_MAX_N     = 8;
   localparam int C_ONEHOT_W  = 1 << C_MAX_N;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sel_state_t;

   // Decode an index into a one-hot vector; callers truncate to their width.
   function automatic logic [C_ONEHOT_W-1:0] onehot(input logic [C_MAX_N-1:0] idx);
      logic [C_ONEHOT_W-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin winner search. The request vector is
//            rotated so that index ptr+1 sits at bit 0, priority encoded from
//            bit 0 upward, and the offset added back modulo 2**N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import mux_sel_pkg::*;
#(
   parameter int N = C_N_DEFAULT
) (
   input  logic [(1<<N)-1:0] req,
   input  logic [N-1:0]      ptr,
   output logic              any,
   output logic [N-1:0]      win
);

   localparam int X = 1 << N;

   logic [N-1:0] w_start;
   logic [X-1:0] w_rot;
   logic [N-1:0] w_off;

   // Search starts just after the last accepted grant; N-bit add wraps naturally.
   assign w_start = ptr + N'(1);

   // Rotate right so the highest-priority requester lands on bit 0.
   always_comb begin
      w_rot = '0;
      for (int j = 0; j < X; j++) begin
         w_rot[j] = req[N'(w_start + N'(j))];
      end
   end

   // Priority encode: lowest set bit of the rotated vector wins.
   always_comb begin
      w_off = '0;
      for (int j = X - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_off = N'(j);
         end
      end
   end

   assign any = |req;
   assign win = w_start + w_off;

endmodule
`default_nettype wire

// File: rtl/mux_sel_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux_sel_rr_arbiter
// Brief    : Round-robin select-line generator for an N:1 mux. Drives a
//            registered select with a valid/ready handshake; each handshake
//            completes one grant and moves the rotating pointer past the
//            winner. Back-to-back grants sustain one grant per cycle.
// Config   : SEL_LOCK_EN - adds a lock input that re-grants the current
//            index on handshake while its request remains asserted.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_rr_arbiter
   import mux_sel_pkg::*;
#(
   parameter int N     = C_N_DEFAULT,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [(1<<N)-1:0]    req,
   input  logic                 sel_ready,
`ifdef SEL_LOCK_EN
   input  logic                 lock,
`endif
   output logic [N-1:0]         s_line,
   output logic                 sel_valid,
   output logic [(1<<N)-1:0]    gnt_onehot,
   output logic [CNT_W-1:0]     grant_cnt
);

   localparam int X = 1 << N;

   sel_state_t       r_state;
   logic [N-1:0]     r_ptr;
   logic [N-1:0]     r_s_line;
   logic             r_sel_valid;
   logic [X-1:0]     r_gnt_onehot;
   logic [CNT_W-1:0] r_grant_cnt;

   logic [N-1:0]     w_pick_ptr;
   logic             w_any;
   logic [N-1:0]     w_win;
   logic             w_hold;
   logic [N-1:0]     w_next;

   // While granting, the follow-on search is relative to the grant being
   // accepted now, since that index becomes the new pointer on this edge.
   assign w_pick_ptr = (r_state == GRANT) ? r_s_line : r_ptr;

   rr_pick #(
      .N   (N)
   ) u_rr_pick (
      .req (req),
      .ptr (w_pick_ptr),
      .any (w_any),
      .win (w_win)
   );

`ifdef SEL_LOCK_EN
   // Burst hold: keep the same index only while it is still requesting.
   assign w_hold = lock & req[r_s_line];
`else
   assign w_hold = 1'b0;
`endif

   assign w_next = w_hold ? r_s_line : w_win;

   // Grant FSM with all outputs registered; a live grant is never withdrawn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_ptr        <= N'(X - 1);
         r_s_line     <= '0;
         r_sel_valid  <= 1'b0;
         r_gnt_onehot <= '0;
         r_grant_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_s_line     <= w_win;
                  r_sel_valid  <= 1'b1;
                  r_gnt_onehot <= X'(onehot(C_MAX_N'(w_win)));
                  r_state      <= GRANT;
               end
            end
            GRANT: begin
               if (sel_ready) begin
                  r_grant_cnt <= r_grant_cnt + CNT_W'(1);
                  if (!w_hold) begin
                     r_ptr <= r_s_line;
                  end
                  if (w_any) begin
                     r_s_line     <= w_next;
                     r_gnt_onehot <= X'(onehot(C_MAX_N'(w_next)));
                  end else begin
                     r_sel_valid  <= 1'b0;
                     r_gnt_onehot <= '0;
                     r_state      <= IDLE;
                  end
               end
            end
            default: begin
               r_state      <= IDLE;
               r_sel_valid  <= 1'b0;
               r_gnt_onehot <= '0;
            end
         endcase
      end
   end

   assign s_line     = r_s_line;
   assign sel_valid  = r_sel_valid;
   assign gnt_onehot = r_gnt_onehot;
   assign grant_cnt  = r_grant_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_rr_arbiter
// Brief    : Self-checking bench for mux_sel_rr_arbiter (N=2). A reference
//            model tracks the expected grant sequence and is compared every
//            cycle; directed literal checks pin the model. The bench also
//            hosts a 4:1 data mux driven by s_line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_rr_arbiter;

   localparam int N     = 2;
   localparam int X     = 1 << N;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [X-1:0]     req = '0;
   logic             sel_ready = 1'b0;
   logic             lock = 1'b0;
   logic [N-1:0]     s_line;
   logic             sel_valid;
   logic [X-1:0]     gnt_onehot;
   logic [CNT_W-1:0] grant_cnt;

   logic [7:0]       data_in [X];
   logic [7:0]       mux_out;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic m_valid;
   int   m_s;
   int   m_ptr;
   int   m_cnt;

   always #5 clk = ~clk;

   mux_sel_rr_arbiter #(
      .N          (N),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .sel_ready  (sel_ready),
`ifdef SEL_LOCK_EN
      .lock       (lock),
`endif
      .s_line     (s_line),
      .sel_valid  (sel_valid),
      .gnt_onehot (gnt_onehot),
      .grant_cnt  (grant_cnt)
   );

   // Downstream mux fed by the arbiter select
   assign mux_out = data_in[s_line];

   // First requester found scanning ptr+1, ptr+2, ... modulo X
   function automatic int pick(input int ptr, input logic [X-1:0] r);
      for (int k = 1; k <= X; k++) begin
         int i;
         i = (ptr + k) % X;
         if (r[i]) return i;
      end
      return 0;
   endfunction

   // Reference model of the grant sequence
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_s     <= 0;
         m_ptr   <= X - 1;
         m_cnt   <= 0;
      end else if (!m_valid) begin
         if (req != '0) begin
            m_s     <= pick(m_ptr, req);
            m_valid <= 1'b1;
         end
      end else if (sel_ready) begin
         m_cnt <= (m_cnt + 1) % (1 << CNT_W);
`ifdef SEL_LOCK_EN
         if (lock && req[m_s]) begin
            m_s <= m_s;
         end else
`endif
         begin
            m_ptr <= m_s;
            if (req != '0) m_s <= pick(m_s, req);
            else           m_valid <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Advance one cycle: compare DUT to model at the falling edge, then
   // return slightly later so the caller can drive new inputs.
   task automatic nxt();
      logic [X-1:0] exp_oh;
      @(negedge clk);
      exp_oh = '0;
      if (m_valid) exp_oh[m_s] = 1'b1;
      chk("mdl_s_line",     32'(s_line),     32'(m_s));
      chk("mdl_sel_valid",  32'(sel_valid),  32'(m_valid));
      chk("mdl_gnt_onehot", 32'(gnt_onehot), 32'(exp_oh));
      chk("mdl_grant_cnt",  32'(grant_cnt),  32'(m_cnt));
      if (m_valid) chk("mdl_mux_out", 32'(mux_out), 32'(data_in[m_s]));
      #2;
   endtask

   logic [X-1:0] vec_tbl [6];

   initial begin
      for (int i = 0; i < X; i++) data_in[i] = 8'hA0 + 8'(i);
      vec_tbl[0] = 4'b1001; vec_tbl[1] = 4'b0110; vec_tbl[2] = 4'b1000;
      vec_tbl[3] = 4'b0001; vec_tbl[4] = 4'b0000; vec_tbl[5] = 4'b1111;

      // 1. Reset values
      nxt();
      chk("t1_s_line",     32'(s_line),     32'd0);
      chk("t1_sel_valid",  32'(sel_valid),  32'd0);
      chk("t1_gnt_onehot", 32'(gnt_onehot), 32'd0);
      chk("t1_grant_cnt",  32'(grant_cnt),  32'd0);
      nxt();
      rst_n = 1'b1;

      // 2. All requesting, consumer always ready: 0,1,2,3,0 back to back
      req = 4'b1111; sel_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         nxt();
         chk("t2_s_line",    32'(s_line),    32'(i % 4));
         chk("t2_sel_valid", 32'(sel_valid), 32'd1);
         chk("t2_grant_cnt", 32'(grant_cnt), 32'(i));
      end
      nxt();
      chk("t2_grant_cnt5", 32'(grant_cnt), 32'd5);
      chk("t2_s_line5",    32'(s_line),    32'd1);
      req = '0;
      nxt();
      chk("t2_idle_valid", 32'(sel_valid), 32'd0);
      sel_ready = 1'b0;

      // 3. Held grant under backpressure, then rotate to the other requester
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
      req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         nxt();
         chk("t3_hold_s_line", 32'(s_line),    32'd1);
         chk("t3_hold_valid",  32'(sel_valid), 32'd1);
         chk("t3_mux_out",     32'(mux_out),   32'hA1);
      end
      sel_ready = 1'b1;
      nxt();
      chk("t3_next_s_line", 32'(s_line),    32'd3);
      chk("t3_grant_cnt",   32'(grant_cnt), 32'd1);
      req = '0;
      nxt();
      chk("t3_idle_valid",  32'(sel_valid), 32'd0);
      chk("t3_idle_s_line", 32'(s_line),    32'd3);
      sel_ready = 1'b0;

      // 4. Sticky grant after request drops
      req = 4'b0100;
      nxt();
      chk("t4_s_line",     32'(s_line),     32'd2);
      chk("t4_gnt_onehot", 32'(gnt_onehot), 32'b0100);
      req = '0;
      nxt();
      chk("t4_sticky_valid", 32'(sel_valid), 32'd1);
      nxt();
      chk("t4_sticky_s",     32'(s_line),    32'd2);
      sel_ready = 1'b1;
      nxt();
      chk("t4_done_valid", 32'(sel_valid),  32'd0);
      chk("t4_done_oh",    32'(gnt_onehot), 32'd0);
      chk("t4_done_cnt",   32'(grant_cnt),  32'd3);
      sel_ready = 1'b0;
      nxt();
      chk("t4_idle_valid", 32'(sel_valid), 32'd0);

      // 5. Asynchronous reset during a live grant
      req = 4'b1111;
      nxt();
      chk("t5_pre_s_line", 32'(s_line), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_s_line", 32'(s_line),     32'd0);
      chk("t5_rst_valid",  32'(sel_valid),  32'd0);
      chk("t5_rst_oh",     32'(gnt_onehot), 32'd0);
      chk("t5_rst_cnt",    32'(grant_cnt),  32'd0);
      nxt();
      rst_n = 1'b1;
      nxt();
      chk("t5_post_s_line", 32'(s_line),    32'd0);
      chk("t5_post_valid",  32'(sel_valid), 32'd1);

      // Mixed patterns with alternating readiness, model-checked
      for (int i = 0; i < 12; i++) begin
         req       = vec_tbl[i % 6];
         sel_ready = i[0];
         nxt();
         nxt();
      end

`ifdef SEL_LOCK_EN
      // 6. Lock holds the grant on the same index, release rotates
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
      req = 4'b0011; lock = 1'b1; sel_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nxt();
         chk("t6_lock_s_line", 32'(s_line),    32'd0);
         chk("t6_lock_cnt",    32'(grant_cnt), 32'(i));
      end
      lock = 1'b0;
      nxt();
      chk("t6_unlock_s_line", 32'(s_line),    32'd1);
      chk("t6_unlock_cnt",    32'(grant_cnt), 32'd3);
`endif

      req = '0; sel_ready = 1'b1; lock = 1'b0;
      nxt();
      nxt();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
